// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block and its duty divider.
package pwm_pkg;

  localparam int DUTY_W   = 10;
  localparam int DIV_ITER = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring fractional divider: quotient = floor(num * 2^DIV_ITER / den), valid for num < den.
// Built only when PWM_CAPTURE_DUTY_EN is defined; start reloads even while busy.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quotient
);

  localparam int IW = $clog2(DIV_ITER + 1);

  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  den_q;
  logic [DUTY_W-1:0] quo_q;
  logic [IW-1:0]     iter_q;
  logic [CNT_W:0]    rem_sh;
  logic              ge;
  logic [CNT_W-1:0]  rem_nx;

  // The remainder always stays below den, so the doubled value needs one extra bit only.
  assign rem_sh = {rem_q, 1'b0};
  assign ge     = rem_sh >= {1'b0, den_q};
  assign rem_nx = CNT_W'(ge ? rem_sh - {1'b0, den_q} : rem_sh);

  // A start in the completion cycle supersedes the finishing result.
  assign done     = busy && (iter_q == IW'(DIV_ITER)) && !start;
  assign quotient = quo_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      iter_q <= '0;
      busy   <= 1'b0;
    end else if (abort) begin
      iter_q <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      rem_q  <= num;
      den_q  <= den;
      quo_q  <= '0;
      iter_q <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (iter_q == IW'(DIV_ITER)) begin
        busy <= 1'b0;
      end else begin
        rem_q  <= rem_nx;
        quo_q  <= {quo_q[DUTY_W-2:0], ge};
        iter_q <= iter_q + IW'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in CLOCK cycles.
// Define PWM_CAPTURE_DUTY_EN to build the duty divider (DUTY/VALID 11 cycles after capture).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              PWM_IN,
  output logic [CNT_W-1:0]  PERIODO,
  output logic [CNT_W-1:0]  ALTO,
  output logic [DUTY_W-1:0] DUTY,
  output logic              VALID,
  output logic              TIMEOUT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_d;
  logic                   rise;
  logic                   fall;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       high_q;
  logic                   open_meas;
  logic                   capture;
  logic                   fall_take;
  logic                   to_hit;
  logic                   cnt_clr;
  logic                   result_evt;

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;

  // The synchronizer keeps running while disabled so re-enabling never fakes an edge.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PWM_IN};
      pwm_d  <= pwm_s;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    open_meas = 1'b0;
    capture   = 1'b0;
    fall_take = 1'b0;
    to_hit    = 1'b0;
    cnt_clr   = 1'b0;
    if (!ENABLE) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (rise) begin
          state_d   = HIGH;
          open_meas = 1'b1;
        end
        HIGH: if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          to_hit  = 1'b1;
          cnt_clr = 1'b1;
        end else if (fall) begin
          state_d   = LOW;
          fall_take = 1'b1;
        end
        LOW: if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          to_hit  = 1'b1;
          cnt_clr = 1'b1;
        end else if (rise) begin
          state_d   = HIGH;
          capture   = 1'b1;
          open_meas = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // cnt_q holds cycles elapsed since the opening rise, so it equals t-t0 when an edge is seen.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_q  <= '0;
      high_q <= '0;
    end else if (cnt_clr) begin
      cnt_q  <= '0;
      high_q <= '0;
    end else begin
      if (open_meas)                                cnt_q <= CNT_W'(1);
      else if (state_q != IDLE && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      if (fall_take) high_q <= cnt_q;
    end
  end

`ifdef PWM_CAPTURE_DUTY_EN
  logic              div_busy;
  logic              div_done;
  logic [DUTY_W-1:0] div_q;

  pwm_duty_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (CLOCK),
    .rst_n    (RESET),
    .start    (capture),
    .abort    (!ENABLE),
    .num      (high_q),
    .den      (cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  assign result_evt = ENABLE & div_busy & div_done;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)          DUTY <= '0;
    else if (result_evt) DUTY <= div_q;
  end
`else
  assign result_evt = capture;
  assign DUTY       = '0;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      PERIODO <= '0;
      ALTO    <= '0;
      VALID   <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      VALID <= result_evt;
      if (capture) begin
        PERIODO <= cnt_q;
        ALTO    <= high_q;
      end
      if (to_hit)          TIMEOUT <= 1'b1;
      else if (result_evt) TIMEOUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of PWM periods plus hand sequences for
// timeout, reset, divider restart and enable-drop corners.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
`ifdef PWM_CAPTURE_DUTY_EN
  localparam int DIV_LAT = 11;
  localparam bit DUTY_ON = 1'b1;
`else
  localparam int DIV_LAT = 0;
  localparam bit DUTY_ON = 1'b0;
`endif
  // Level driven one cycle after the bench step, SYNC flops, one edge-detect cycle
  // to open, then 2^CNT_W-1 counts before the flag registers.
  localparam int TO_LAT = 1 + SYNC + 1 + (2**CNT_W - 1);

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              pwm_in;
  logic [CNT_W-1:0]  periodo;
  logic [CNT_W-1:0]  alto;
  logic [DUTY_W-1:0] duty;
  logic              valid;
  logic              timeout;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .CLOCK   (clk),
    .RESET   (rst_n),
    .ENABLE  (en),
    .PWM_IN  (pwm_in),
    .PERIODO (periodo),
    .ALTO    (alto),
    .DUTY    (duty),
    .VALID   (valid),
    .TIMEOUT (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Free-running PWM source, updated 1 time unit after each rising edge.
  int gen_period = 1;
  int gen_high   = 0;
  int ph         = 0;
  bit gen_on     = 1'b0;
  bit gen_level  = 1'b0;

  initial begin
    pwm_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gen_on) begin
        pwm_in = (ph < gen_high);
        ph     = (ph + 1 >= gen_period) ? 0 : ph + 1;
      end else begin
        pwm_in = gen_level;
        ph     = 0;
      end
    end
  end

  // Output monitor sampled on the falling edge.
  int cyc = 0;
  int vcount = 0;
  int vhigh = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;
  int upd_cyc = 0;
  logic valid_q = 1'b0;
  logic [CNT_W-1:0] per_q = '0;
  logic [CNT_W-1:0] alto_q = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) vhigh <= vhigh + 1;
    if (valid && !valid_q) begin
      vcount    <= vcount + 1;
      prev_vcyc <= last_vcyc;
      last_vcyc <= cyc;
    end
    valid_q <= valid;
    if (periodo != per_q || alto != alto_q) upd_cyc <= cyc;
    per_q  <= periodo;
    alto_q <= alto;
  end

  initial begin
    #(99000 * 10);
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected end earlier", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic quiesce();
    en        = 1'b0;
    gen_on    = 1'b0;
    gen_level = 1'b0;
    tick(5);
    en = 1'b1;
    tick(5);
  endtask

  task automatic start_gen(input int p, input int h);
    gen_period = p;
    gen_high   = h;
    gen_on     = 1'b1;
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int i = 0;
    while (vcount < target && i < budget) begin
      tick(1);
      i++;
    end
    check({name, " valid seen"}, longint'(vcount >= target), 1);
  endtask

  typedef struct {
    int period;
    int high;
    int exp_per;
    int exp_alto;
    int exp_duty;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int vc0;
    int vc1;
    int i;

    vecs[0] = '{1000, 250, 1000, 250,  256};
    vecs[1] = '{ 400, 100,  400, 100,  256};
    vecs[2] = '{ 100,  33,  100,  33,  337};
    vecs[3] = '{  37,   1,   37,   1,   27};
    vecs[4] = '{  50,  49,   50,  49, 1003};
    vecs[5] = '{  64,  32,   64,  32,  512};
    vecs[6] = '{1000, 250, 1000, 250,  256};

    rst_n = 1'b0;
    en    = 1'b0;
    tick(3);
    check("reset periodo", periodo, 0);
    check("reset alto", alto, 0);
    check("reset duty", duty, 0);
    check("reset valid", valid, 0);
    check("reset timeout", timeout, 0);
    rst_n = 1'b1;

    // Table: first rise only opens, second rise closes, third repeats one period later.
    for (int k = 0; k < 7; k++) begin
      quiesce();
      vc0 = vcount;
      start_gen(vecs[k].period, vecs[k].high);
      wait_valid(vc0 + 1, 2 * vecs[k].period + 40, $sformatf("v%0d first", k));
      check($sformatf("v%0d periodo", k), periodo, vecs[k].exp_per);
      check($sformatf("v%0d alto", k), alto, vecs[k].exp_alto);
      check($sformatf("v%0d duty", k), duty, DUTY_ON ? vecs[k].exp_duty : 0);
      check($sformatf("v%0d valid latency", k), last_vcyc - upd_cyc, DIV_LAT);
      wait_valid(vc0 + 2, vecs[k].period + 40, $sformatf("v%0d second", k));
      check($sformatf("v%0d valid spacing", k), last_vcyc - prev_vcyc, vecs[k].period);
    end

    // Timeout: input stuck high after one rise; outputs keep the last table result.
    quiesce();
    vc0 = vcount;
    gen_level = 1'b1;
    i = 0;
    while (!timeout && i < 70000) begin
      tick(1);
      i++;
    end
    check("timeout latency", i, TO_LAT);
    check("timeout periodo held", periodo, 1000);
    check("timeout alto held", alto, 250);
    check("timeout duty held", duty, DUTY_ON ? 256 : 0);
    check("timeout no valid", vcount, vc0);
    gen_level = 1'b0;
    tick(5);
    check("timeout sticky", timeout, 1);
    start_gen(400, 100);
    wait_valid(vc0 + 1, 1000, "timeout recovery");
    check("timeout cleared", timeout, 0);
    check("recovery periodo", periodo, 400);
    check("recovery alto", alto, 100);

    // Reset in the middle of a period discards it.
    quiesce();
    start_gen(200, 60);
    tick(100);
    rst_n = 1'b0;
    tick(3);
    check("midreset periodo", periodo, 0);
    check("midreset alto", alto, 0);
    check("midreset duty", duty, 0);
    check("midreset valid", valid, 0);
    check("midreset timeout", timeout, 0);
    rst_n = 1'b1;
    vc0 = vcount;
    tick(290);
    check("midreset no early valid", vcount, vc0);
    wait_valid(vc0 + 1, 100, "midreset");
    check("midreset result periodo", periodo, 200);
    check("midreset result alto", alto, 60);
    check("midreset result duty", duty, DUTY_ON ? 307 : 0);

    // Captures every 6 cycles: the divider keeps restarting, only the last one completes.
    quiesce();
    vc0 = vcount;
    start_gen(6, 3);
    tick(30);
    gen_on    = 1'b0;
    gen_level = 1'b0;
    tick(40);
    check("restart valid count", vcount - vc0, DUTY_ON ? 1 : 4);
    check("restart periodo", periodo, 6);
    check("restart alto", alto, 3);
    check("restart duty", duty, DUTY_ON ? 512 : 0);

    // Enable dropped for 50 cycles in the low phase.
    quiesce();
    vc0 = vcount;
    start_gen(200, 60);
    wait_valid(vc0 + 1, 500, "endrop setup");
    i = 0;
    while (ph != 100 && i < 400) begin
      tick(1);
      i++;
    end
    en = 1'b0;
    tick(50);
    check("endrop periodo held", periodo, 200);
    check("endrop alto held", alto, 60);
    check("endrop duty held", duty, DUTY_ON ? 307 : 0);
    check("endrop timeout held", timeout, 0);
    check("endrop no valid", vcount, vc0 + 1);
    en = 1'b1;
    vc1 = vcount;
    tick(200);
    check("endrop first rise opens only", vcount, vc1);
    wait_valid(vc1 + 1, 200, "endrop resume");
    check("endrop resume periodo", periodo, 200);
    check("endrop resume alto", alto, 60);

    tick(2);
    check("valid single-cycle pulses", vhigh, vcount);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter: CNT_W, default 16, width of the period and high-time counters and outputs.
REQ-002 Parameter: SYNC_STAGES, default 2, number of input synchronizer flops (minimum 2).
REQ-003 Port: CLOCK  in  1  the single clock; one clock, all logic on its rising edge.
REQ-004 Port: RESET  in  1  reset is asynchronous and active-low.
REQ-005 Port: ENABLE  in  1  capture enable; low aborts any measurement in progress.
REQ-006 Port: PWM_IN  in  1  asynchronous PWM waveform under measurement.
REQ-007 Port: PERIODO  out  CNT_W  last measured period, in CLOCK cycles.
REQ-008 Port: ALTO  out  CNT_W  last measured high time, in CLOCK cycles.
REQ-009 Port: DUTY  out  10  last duty cycle, scaled 0..1023 (same scale as the 10-bit PWM reference).
REQ-010 Port: VALID  out  1  one-cycle pulse when a new result is present on the outputs.
REQ-011 Port: TIMEOUT  out  1  level; no closing edge seen within 2^CNT_W-1 cycles.

Function
REQ-012 PWM_IN SHALL pass through SYNC_STAGES flops, and then through one edge-detect register.
REQ-013 A detected edge is defined as the cycle in which the synchronized value differs from its registered copy.
REQ-014 The FSM SHALL have these states and transitions:
- IDLE -> HIGH on a detected rising edge.
- HIGH -> LOW on a detected falling edge.
- LOW -> HIGH on a detected rising edge.
REQ-015 For detected rising edges at cycles t0 and t2, and the falling edge between them at t1:
- the period result SHALL be t2-t0;
- the high-time result SHALL be t1-t0.
REQ-016 On the cycle after the closing rising edge, PERIODO and ALTO SHALL update together, and the counter SHALL restart for the next period.
REQ-017 The first rising edge after reset, after ENABLE rises, or after a timeout SHALL only open a measurement; it produces no result.
REQ-018 If the counter reaches 2^CNT_W-1 in HIGH or LOW, the block SHALL:
- set TIMEOUT;
- go to IDLE;
- clear the counters;
- leave PERIODO, ALTO and DUTY unchanged.
REQ-019 TIMEOUT SHALL clear on the next VALID pulse.
REQ-020 When ENABLE is low, the block SHALL:
- force IDLE;
- clear the counters;
- abort the divider;
- suppress VALID;
- hold PERIODO, ALTO, DUTY and TIMEOUT at their last values.
REQ-021 Counters SHALL saturate and never wrap.

Reset
REQ-022 While RESET is low, all of the following SHALL be 0 and the FSM SHALL be in IDLE:
- PERIODO, ALTO, DUTY, VALID, TIMEOUT;
- the counters and the synchronizer flops.
REQ-023 Release SHALL be honored on the first CLOCK edge, with no pending result.
REQ-024 A reset during a measurement SHALL discard that measurement.

Configuration
REQ-025 Macro PWM_CAPTURE_DUTY_EN defined: the divider SHALL be built with this behaviour.
- DUTY = floor(ALTO*1024/PERIODO), computed by a 10-iteration restoring divider.
- DUTY and VALID SHALL update exactly 11 cycles after PERIODO/ALTO update.
- A new capture while the divider is busy SHALL restart it with the new operands.
- The older result SHALL be dropped, with no VALID for it.
REQ-026 Macro PWM_CAPTURE_DUTY_EN undefined: no divider logic SHALL be built, with this behaviour.
- DUTY SHALL be constant 0.
- VALID SHALL pulse in the same cycle that PERIODO/ALTO update.

Structure
REQ-027 The shared package pwm_pkg SHALL hold:
- the FSM state typedef (IDLE, HIGH, LOW);
- constant DUTY_W = 10;
- constant DIV_ITER = 10.
REQ-028 The divider SHALL be the separate sub-module pwm_duty_div, with start/busy/done handshake and async active-low reset.
REQ-029 The sub-module SHALL be instantiated only under PWM_CAPTURE_DUTY_EN.

Verification
REQ-030 Scenario, period 1000 / high 250 / duty enabled, repeated: second rising edge -> PERIODO=1000, ALTO=250; 11 cycles later DUTY=256 with one VALID pulse.
REQ-031 Scenario, PWM_IN held high after one rising edge: TIMEOUT=1 after 65535 cycles, outputs unchanged; the next good period then clears TIMEOUT and gives VALID.
REQ-032 Scenario, RESET low mid-period then released, followed by two full periods: no VALID for the first period, and a correct result after the second.
REQ-033 Scenario, period 6 / high 3 / duty enabled, for 5 periods: the divider restarts each time, VALID never fires during a restart, and the final DUTY=512.
REQ-034 Scenario, ENABLE dropped for 50 cycles during LOW: outputs hold, no VALID; after re-enable, the first rising edge opens a measurement only.
REQ-035 Scenario, duty disabled, period 400 / high 100: DUTY=0, and VALID coincides with PERIODO=400, ALTO=100.
